// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin two-master arbiter that runs each peripheral access as a fixed-length transaction.
module periph_bus_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic        m0_we,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic        m1_we,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [31:0] m1_rd,
    output logic [31:0] bus_wa,
    output logic [31:0] bus_wd,
    output logic        bus_we,
    input  logic [31:0] bus_rd,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        owner, owner_nx, last_gnt, last_gnt_nx, we_q, we_nx, pick;
    logic [31:0] addr_q, addr_nx, wd_q, wd_nx, rd_q, rd_nx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            rd_q     <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            owner    <= owner_nx;
            last_gnt <= last_gnt_nx;
            we_q     <= we_nx;
            addr_q   <= addr_nx;
            wd_q     <= wd_nx;
            rd_q     <= rd_nx;
        end
    end
    // on a tie the master that did not win last time gets the bus
    assign pick = (m0_req && m1_req) ? ~last_gnt : m1_req;
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        owner_nx    = owner;
        last_gnt_nx = last_gnt;
        we_nx       = we_q;
        addr_nx     = addr_q;
        wd_nx       = wd_q;
        rd_nx       = rd_q;
        case (state)
            IDLE: if (m0_req || m1_req) begin
                state_nx    = ACCESS;
                owner_nx    = pick;
                last_gnt_nx = pick;
                addr_nx     = pick ? m1_addr : m0_addr;
                wd_nx       = pick ? m1_wd : m0_wd;
                we_nx       = pick ? m1_we : m0_we;
                cnt_nx      = CNT_INIT;
            end
            ACCESS: if (cnt == 4'd0) begin
                state_nx = DONE;
                rd_nx    = bus_rd;
            end else begin
                cnt_nx = cnt - 4'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign busy   = state != IDLE;
    assign bus_wa = (state == ACCESS) ? addr_q : '0;
    assign bus_wd = (state == ACCESS) ? wd_q : '0;
    assign bus_we = (state == ACCESS) && we_q && (cnt == 4'd0);
    assign m0_gnt = busy && !owner;
    assign m1_gnt = busy && owner;
    assign m0_ack = (state == DONE) && !owner;
    assign m1_ack = (state == DONE) && owner;
    assign m0_rd  = rd_q;
    assign m1_rd  = rd_q;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: scoreboarded directed test of the arbiter, plus a WAIT_CYCLES=1 instance.
module tb_periph_bus_arbiter;
    localparam int W = 2;
    localparam logic [31:0] LED = 32'h1000_0000, DIP = 32'h1000_0004, SEG = 32'h1000_0008;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wd = 0, m1_addr = 0, m1_wd = 0;
    logic m0_gnt, m0_ack, m1_gnt, m1_ack, bus_we, busy;
    logic [31:0] m0_rd, m1_rd, bus_wa, bus_wd, bus_rd;
    logic s_m0_req = 0, s_m0_we = 0;
    logic [31:0] s_m0_addr = 0, s_m0_wd = 0;
    logic s_m0_gnt, s_m0_ack, s_m1_gnt, s_m1_ack, s_bus_we, s_busy;
    logic [31:0] s_m0_rd, s_m1_rd, s_bus_wa, s_bus_wd;
    logic [31:0] s_bus_rd = 32'h77;

    function automatic logic [31:0] rd_f(input logic [31:0] a);
        return (a == DIP) ? 32'h0000_00A5 : (a ^ 32'hC0DE_0000);
    endfunction
    assign bus_rd = rd_f(bus_wa);

    periph_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rd(m1_rd),
        .bus_wa(bus_wa), .bus_wd(bus_wd), .bus_we(bus_we), .bus_rd(bus_rd), .busy(busy)
    );
    periph_bus_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .m0_req(s_m0_req), .m0_addr(s_m0_addr), .m0_wd(s_m0_wd), .m0_we(s_m0_we),
        .m0_gnt(s_m0_gnt), .m0_ack(s_m0_ack), .m0_rd(s_m0_rd),
        .m1_req(1'b0), .m1_addr(32'h0), .m1_wd(32'h0), .m1_we(1'b0),
        .m1_gnt(s_m1_gnt), .m1_ack(s_m1_ack), .m1_rd(s_m1_rd),
        .bus_wa(s_bus_wa), .bus_wd(s_bus_wd), .bus_we(s_bus_we), .bus_rd(s_bus_rd), .busy(s_busy)
    );

    typedef struct {logic m; logic we; logic [31:0] addr; logic [31:0] wd; logic [31:0] rd; int cyc;} exp_t;
    exp_t q[$];
    int vectors = 0, miscompares = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: tracks bus activity per transaction and scores it when an ack appears
    logic [31:0] wa_seen = 0, st_wd = 0;
    int acc_n = 0, st_n = 0, st_at = 0;
    logic wa_err = 0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            acc_n = 0; st_n = 0; st_at = 0; wa_err = 0; wa_seen = 0;
        end else begin
            if (bus_wa != 0) begin
                if (acc_n == 0) wa_seen = bus_wa;
                else if (bus_wa !== wa_seen) wa_err = 1;
                acc_n++;
            end
            if (bus_we) begin
                st_n++; st_wd = bus_wd; st_at = acc_n;
            end
            if (m0_ack || m1_ack) begin
                if (q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ack_owner", {31'b0, m1_ack}, {31'b0, e.m});
                    check("ack_both", {31'b0, m0_ack && m1_ack}, 32'd0);
                    check("ack_cycle", cyc, e.cyc);
                    check("rd_data", m1_ack ? m1_rd : m0_rd, e.rd);
                    check("bus_addr", wa_seen, e.addr);
                    check("addr_stable", {31'b0, wa_err}, 32'd0);
                    check("access_len", acc_n, W);
                    check("strobes", st_n, {31'b0, e.we});
                    if (e.we) begin
                        check("strobe_wd", st_wd, e.wd);
                        check("strobe_last", st_at, W);
                    end
                    check("own_gnt", {31'b0, m1_ack ? m1_gnt : m0_gnt}, 32'd1);
                    check("other_gnt", {31'b0, m1_ack ? m0_gnt : m1_gnt}, 32'd0);
                    check("done_bus_idle", bus_wa | bus_wd | {31'b0, bus_we}, 32'd0);
                end
                acc_n = 0; st_n = 0; st_at = 0; wa_err = 0; wa_seen = 0;
            end
        end
    end

    task automatic drive(input logic m, input logic [31:0] a, input logic [31:0] wd, input logic we);
        if (m) begin m1_req = 1; m1_addr = a; m1_wd = wd; m1_we = we; end
        else begin m0_req = 1; m0_addr = a; m0_wd = wd; m0_we = we; end
    endtask

    task automatic push(input logic m, input logic [31:0] a, input logic [31:0] wd, input logic we, input int c);
        q.push_back('{m, we, a, wd, rd_f(a), c});
    endtask

    task automatic wait_acks(input int n, input string name);
        int got = 0;
        for (int i = 0; i < 60 && got < n; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) got++;
        end
        if (got < n) check(name, got, n);
        m0_req = 0; m1_req = 0;
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        check("rst_gnt", {30'b0, m0_gnt, m1_gnt}, 32'd0);
        check("rst_ack", {30'b0, m0_ack, m1_ack}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_bus", bus_wa | bus_wd | {31'b0, bus_we}, 32'd0);
        check("rst_rd", m0_rd, 32'd0);
        rst = 0;
        // single m0 read of DIP
        drive(0, DIP, 32'h0, 0);
        push(0, DIP, 32'h0, 0, cyc + 1 + W);
        wait_acks(1, "t1_timeout");
        @(negedge clk);
        check("t1_idle", {31'b0, busy}, 32'd0);
        check("t1_rd_hold", m0_rd, 32'h0000_00A5);
        // m1 write to LED
        drive(1, LED, 32'h1234_5678, 1);
        push(1, LED, 32'h1234_5678, 1, cyc + 1 + W);
        wait_acks(1, "t2_timeout");
        @(negedge clk);
        check("t2_idle", {31'b0, busy}, 32'd0);
        // inputs change and req drops during ACCESS
        drive(0, SEG, 32'hDEAD_0001, 1);
        push(0, SEG, 32'hDEAD_0001, 1, cyc + 1 + W);
        @(negedge clk);
        m0_addr = 32'h1000_0FF0; m0_wd = 32'h0000_0BAD; m0_req = 0;
        wait_acks(1, "t3_timeout");
        @(negedge clk);
        // async reset during a write access, before its strobe
        drive(0, LED, 32'h0000_CAFE, 1);
        @(negedge clk);
        check("t4_pre_gnt", {31'b0, m0_gnt}, 32'd1);
        #2 rst = 1;
        #1;
        check("t4_we", {31'b0, bus_we}, 32'd0);
        check("t4_gnt", {31'b0, m0_gnt}, 32'd0);
        check("t4_busy", {31'b0, busy}, 32'd0);
        m0_req = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        check("t4_idle", {31'b0, busy}, 32'd0);
        // both masters hold req from reset: m0 wins first, then strict alternation
        c = cyc;
        drive(0, DIP, 32'h0, 0);
        drive(1, LED, 32'h0F0F_0F0F, 1);
        push(0, DIP, 32'h0, 0, c + 1 + W);
        push(1, LED, 32'h0F0F_0F0F, 1, c + 1 + 2 * W + 2);
        push(0, DIP, 32'h0, 0, c + 1 + 3 * W + 4);
        push(1, LED, 32'h0F0F_0F0F, 1, c + 1 + 4 * W + 6);
        wait_acks(4, "t5_timeout");
        @(negedge clk);
        check("t5_idle", {31'b0, busy}, 32'd0);
        check("queue_empty", q.size(), 32'd0);
        // WAIT_CYCLES=1 instance: one-cycle access, three-cycle spacing
        s_m0_req = 1; s_m0_we = 1; s_m0_addr = LED; s_m0_wd = 32'h55;
        @(negedge clk);
        check("w1_we", {31'b0, s_bus_we}, 32'd1);
        check("w1_wd", s_bus_wd, 32'h55);
        check("w1_gnt", {30'b0, s_m0_gnt, s_m0_ack}, 32'd2);
        @(negedge clk);
        check("w1_ack", {31'b0, s_m0_ack}, 32'd1);
        check("w1_we_done", {31'b0, s_bus_we}, 32'd0);
        check("w1_rd", s_m0_rd, 32'h77);
        @(negedge clk);
        check("w1_idle", {30'b0, s_busy, s_m0_ack}, 32'd0);
        @(negedge clk);
        check("w1_we2", {31'b0, s_bus_we}, 32'd1);
        @(negedge clk);
        check("w1_ack2", {31'b0, s_m0_ack}, 32'd1);
        s_m0_req = 0;
        @(negedge clk);
        check("w1_end", {31'b0, s_busy}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter and access sequencer for the shared memory-mapped peripheral bus (LED, DIP, SEG decode). It sits between the peripheral address decoder and two bus masters: m0 (CPU data port) and m1 (debug/loader engine). It grants the bus round-robin and runs each access as a fixed-length multi-cycle transaction. The write strobe is a single-cycle pulse, and the read data is registered before acknowledge.

## Interface
Parameters:
- WAIT_CYCLES, default 2: number of cycles the bus is driven per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  m0 access request; held high until m0_ack.
- m0_addr  in  32  m0 word address.
- m0_wd  in  32  m0 write data.
- m0_we  in  1  m0 access is a write (1) or a read (0).
- m0_gnt  out  1  m0 owns the bus (ACCESS and DONE states).
- m0_ack  out  1  one-cycle completion pulse for m0.
- m0_rd  out  32  read data; valid while m0_ack=1.
- m1_req, m1_addr, m1_wd, m1_we, m1_gnt, m1_ack, m1_rd: same as the m0 ports, for m1.
- bus_wa  out  32  address to the peripheral decoder.
- bus_wd  out  32  write data to the peripheral decoder.
- bus_we  out  1  write strobe to the peripheral decoder.
- bus_rd  in  32  combinational read data from the peripheral decoder.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that master.
  - Both requesting: grant the master that is not last_gnt.
  - On grant: latch addr/wd/we into internal registers, set owner and last_gnt, load cnt=WAIT_CYCLES-1, go to ACCESS.
- ACCESS:
  - bus_wa and bus_wd are driven from the latched registers.
  - bus_we = latched_we AND (cnt==0), so each write produces exactly one strobe.
  - cnt decrements each cycle.
  - At cnt==0: capture bus_rd into rd_reg (captured for writes too; the value is ignored), then go to DONE.
- DONE: the owner's ack is 1 for one cycle and its gnt stays high; then go to IDLE unconditionally.
- Outside ACCESS: bus_wa=0, bus_wd=0, bus_we=0. This drives the decoder to an undecoded state, so no DIP read is selected.
- m0_rd = m1_rd = rd_reg. rd_reg holds its value until the next capture.
- Request inputs are sampled only in IDLE. Changes to req/addr/wd/we during ACCESS or DONE have no effect, and dropping req mid-transaction does not abort it.
- Requester protocol: deassert req on the edge that samples ack=1. A req still high in the following IDLE cycle is a new request.
- Counter width: 4 bits. WAIT_CYCLES=1 gives cnt=0 on ACCESS entry, so the access is a single cycle with the strobe in that cycle.

## Timing
- Reset values:
  - state=IDLE, cnt=0, owner=0, last_gnt=1 (m0 wins the first tie), rd_reg=0.
  - All gnt, ack, busy = 0; bus_wa, bus_wd, bus_we = 0.
- Latency, with the request sampled at edge k:
  - gnt and busy rise after edge k.
  - ACCESS occupies WAIT_CYCLES cycles; bus_we is high only in the last of them.
  - ack is high for the one cycle after edge k+WAIT_CYCLES.
  - State is IDLE after edge k+WAIT_CYCLES+1.
- Throughput: one transaction per WAIT_CYCLES+2 cycles, because the mandatory IDLE cycle separates back-to-back grants.
- Simultaneous requests: strictly alternating grants while both masters hold req.
- Reset asserted mid-ACCESS: all outputs go to their reset values immediately (asynchronous, with no clock edge needed). No ack is issued and no further bus_we pulse occurs.

## Test plan
- Reset then a single m0 read of DIP (bus_rd=0x0000_00A5, WAIT_CYCLES=2), request sampled at edge 1 -> bus_wa=DIP address in cycles 2-3, bus_we=0 throughout, m0_ack=1 only in cycle 4, m0_rd=0x0000_00A5, IDLE in cycle 5.
- m1 write of 0x1234_5678 to LED -> bus_we high for exactly one cycle (the last ACCESS cycle) with bus_wd=0x1234_5678; m0_gnt stays 0; m1_ack is one cycle.
- m0 and m1 request simultaneously from reset and hold req after each ack -> grant order m0, m1, m0, m1, with each transaction spaced WAIT_CYCLES+2 cycles.
- m0 changes m0_addr and m0_wd and drops m0_req during ACCESS -> bus_wa/bus_wd keep the latched values and ack still fires.
- rst asserted between clock edges during ACCESS of a write, before the strobe cycle -> bus_we, gnt and busy drop immediately, no ack, state IDLE after release, and last_gnt=1.
- WAIT_CYCLES=1 build -> ACCESS lasts one cycle with bus_we in it, ack on the next cycle, and 3-cycle transaction spacing.
